sprite_loader: RTL
==================

SPRITE_LOADER -- requirements
Module: sprite_loader

Interface
REQ-001 Parameter ADDR_BITS, default 16, SHALL set the image-RAM address width; a frame is 2^ADDR_BITS bytes.
REQ-002 Parameter TIMEOUT, default 1000000, SHALL set the maximum idle cycles allowed between accepted bytes while loading.
REQ-003 Parameter SYNC0, default 8'hA5, SHALL be the first header byte.
REQ-004 Parameter SYNC1, default 8'h5A, SHALL be the second header byte.
REQ-005 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-006 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-007 start  input  1  SHALL be a single-cycle request to begin a new load.
REQ-008 in_data  input  8  SHALL carry the incoming byte.
REQ-009 in_valid  input  1  SHALL be high when in_data holds a byte.
REQ-010 in_ready  output  1  SHALL be high when the block accepts a byte this cycle.
REQ-011 ram_we  output  1  SHALL be the write strobe to the image-RAM write port.
REQ-012 ram_addr  output  ADDR_BITS  SHALL be the write address.
REQ-013 ram_wdata  output  8  SHALL be the write data, packed {blue[1:0], green[2:0], red[2:0]}, passed through unmodified.
REQ-014 busy  output  1  SHALL be high in HDR0, HDR1 and LOAD.
REQ-015 done  output  1  SHALL be high in DONE.
REQ-016 error  output  1  SHALL be high in ERROR.
REQ-017 checksum  output  8  SHALL hold the running modulo-256 sum of payload bytes.

Function
REQ-018 The block SHALL implement the states IDLE, HDR0, HDR1, LOAD, DONE and ERROR.
REQ-019 A byte SHALL be accepted only on a cycle with in_valid=1 and in_ready=1; in_ready SHALL be 1 exactly in HDR0, HDR1 and LOAD.
REQ-020 start=1 in IDLE, DONE or ERROR SHALL move to HDR0 next cycle and clear the address counter, checksum and timeout counter.
REQ-021 start SHALL be ignored in HDR0, HDR1 and LOAD.
REQ-022 HDR0 transitions:
- accepted SYNC0 -> HDR1
- any other accepted byte -> stay in HDR0
REQ-023 HDR1 transitions:
- accepted SYNC1 -> LOAD
- accepted SYNC0 -> stay in HDR1
- any other accepted byte -> HDR0
REQ-024 Header bytes SHALL NOT be written to RAM or added to checksum.
REQ-025 Each byte accepted in LOAD SHALL produce, on the following cycle only, ram_we=1, ram_addr = current counter, ram_wdata = the byte (write latency 1 cycle).
REQ-026 ram_we SHALL be 0 on all other cycles.
REQ-027 Addresses SHALL run 0 .. 2^ADDR_BITS-1 with no gaps, incrementing by one per accepted byte.
REQ-028 checksum SHALL update in the same cycle as the corresponding ram_we.
REQ-029 Accepting byte number 2^ADDR_BITS-1 (the last address) SHALL move to DONE.
REQ-030 in_ready SHALL be 0 from the cycle after the last accepted byte; that byte's write still occurs.
REQ-031 The address counter SHALL NOT wrap to 0 for writing within a frame.
REQ-032 The timeout counter SHALL clear on every accepted byte and on entry to HDR0.
REQ-033 The timeout counter SHALL increment on every other cycle spent in HDR0, HDR1 or LOAD.
REQ-034 On reaching TIMEOUT-1 without an accepted byte, the block SHALL move to ERROR.
REQ-035 In ERROR no further RAM write SHALL occur; the address and checksum values SHALL be held for inspection.
REQ-036 DONE and ERROR SHALL persist until start or reset.
REQ-037 If a byte is accepted in the same cycle the timeout threshold is reached, the byte SHALL take priority and the timeout SHALL NOT fire.

Reset
REQ-038 reset=1 SHALL force IDLE on the next edge, overriding start and any accepted byte.
REQ-039 During reset, in_ready, ram_we, busy, done and error SHALL be 0, and ram_addr, ram_wdata and checksum SHALL be 0.
REQ-040 A reset in the middle of LOAD SHALL abort the load; the write of a byte accepted in that same cycle SHALL be suppressed.

Verification (ADDR_BITS=4, TIMEOUT=16)
REQ-041 Normal load: start, then A5 5A 00..0F with in_valid held high -> 16 writes at addr 0..15 with data 00..0F; checksum=78; done=1 one cycle after the last write.
REQ-042 Header resync: A5 A5 5A, then 16 bytes of 01 -> first write at addr 0 data 01; checksum=10.
REQ-043 Bad header: A5 33 A5 5A, then payload -> the 33 is dropped, stays in HDR0, then the load completes normally.
REQ-044 Timeout: after 5 payload bytes, in_valid held low for 16 cycles -> error=1; ram_addr frozen at 4; no further ram_we.
REQ-045 Abort and restart: reset asserted mid-load with in_valid=1 -> no write that cycle, all outputs 0; a following start with a full frame completes with done=1.
REQ-046 Backpressure and start: start pulsed during LOAD, and in_valid toggled every other cycle -> start ignored; writes remain contiguous; done=1 after 16 writes.

Source files
------------

// File: rtl/sprite_loader.sv
// Sprite image loader: finds a two-byte sync header in a byte stream, then writes one
// frame of packed RGB pixels to image RAM while keeping a running modulo-256 checksum.
module sprite_loader #(
  parameter int          ADDR_BITS = 16,
  parameter int          TIMEOUT   = 1000000,
  parameter logic [7:0]  SYNC0     = 8'hA5,
  parameter logic [7:0]  SYNC1     = 8'h5A
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [7:0]           ram_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [7:0]           checksum
);

  localparam int                   TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]        T_LAST = TW'(TIMEOUT - 1);
  localparam logic [ADDR_BITS-1:0] A_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_LOAD, S_DONE, S_ERROR
  } state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] cnt;
  logic [TW-1:0]        idle_cnt;
  logic [7:0]           sum;
  logic                 vld_p1;
  logic [ADDR_BITS-1:0] addr_p1;
  logic [7:0]           wdata_p1;
  logic                 active;
  logic                 accept;

  function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  assign active = (state == S_HDR0) || (state == S_HDR1) || (state == S_LOAD);
  assign accept = in_valid & in_ready;

  // Outputs are forced to zero for the whole cycle reset is asserted.
  assign in_ready  = active & ~reset;
  assign busy      = active & ~reset;
  assign done      = (state == S_DONE) & ~reset;
  assign error     = (state == S_ERROR) & ~reset;
  assign ram_we    = vld_p1 & ~reset;
  assign ram_addr  = reset ? '0 : addr_p1;
  assign ram_wdata = reset ? '0 : wdata_p1;
  assign checksum  = reset ? '0 : sum;

  // Stage p0 -> p1: accepted payload byte becomes a RAM write on the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idle_cnt <= '0;
      sum      <= '0;
      vld_p1   <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
    end else begin
      vld_p1 <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state    <= S_HDR0;
            cnt      <= '0;
            idle_cnt <= '0;
            sum      <= '0;
            addr_p1  <= '0;
          end
        end
        default: begin
          if (accept) begin
            idle_cnt <= '0;
            case (state)
              S_HDR0: begin
                if (in_data == SYNC0) state <= S_HDR1;
              end
              S_HDR1: begin
                if (in_data == SYNC1)      state <= S_LOAD;
                else if (in_data != SYNC0) state <= S_HDR0;
              end
              S_LOAD: begin
                vld_p1   <= 1'b1;
                addr_p1  <= cnt;
                wdata_p1 <= in_data;
                sum      <= csum_add(sum, in_data);
                // Last address ends the frame; the counter never wraps back to 0.
                if (cnt == A_LAST) state <= S_DONE;
                else               cnt   <= cnt + 1'b1;
              end
              default: ;
            endcase
          end else if (idle_cnt == T_LAST) begin
            state <= S_ERROR;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
